// File: rtl/csr_serializer_pkg.sv
// Shared types and constants for the serializing-instruction sequencer.
package csr_serializer_pkg;

    typedef enum logic [1:0] {
        KindSatpWr    = 2'd0,
        KindSfence    = 2'd1,
        KindFenceI    = 2'd2,
        KindDrainOnly = 2'd3
    } req_kind_e;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StCommit,
        StFlush,
        StRedirect
    } state_e;

    localparam logic [11:0] CsrAddrSatp = 12'h180;
    localparam logic [11:0] CsrAddrMepc = 12'h341;

endpackage

// File: rtl/csr_serializer.sv
// Sequences satp writes / sfence.vma / fence.i: drain the pipe, commit the CSR,
// flush the TLB or I-cache, then redirect fetch to the following instruction.
module csr_serializer
    import csr_serializer_pkg::*;
#(
    parameter int unsigned REG_WIDTH   = 64,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [1:0]           req_kind,
    input  logic [REG_WIDTH-1:0] req_next_pc,
    output logic                 req_ready,
    input  logic                 pipe_empty,
    output logic                 stall_fetch,
    output logic                 csr_commit,
    output logic                 tlb_flush_req,
    input  logic                 tlb_flush_ack,
    output logic                 icache_inv_req,
    input  logic                 icache_inv_ack,
    output logic                 redirect_valid,
    output logic [REG_WIDTH-1:0] redirect_pc,
    output logic                 busy,
    output logic                 flush_timeout
);

    localparam logic [8:0] TimeoutLimit = 9'(ACK_TIMEOUT);

    state_e               state_q, state_d;
    req_kind_e            kind_q, kind_d;
    logic [REG_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic use_tlb, use_icache, flush_ack, cnt_last;

    assign use_tlb    = (kind_q == KindSatpWr) || (kind_q == KindSfence);
    assign use_icache = (kind_q == KindFenceI);
    // Only the ack of the resource actually being flushed counts.
    assign flush_ack  = (use_tlb && tlb_flush_ack) || (use_icache && icache_inv_ack);
    // True in the FLUSH cycle whose increment makes the count reach the limit.
    assign cnt_last   = ({1'b0, cnt_q} + 9'd1) >= TimeoutLimit;

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        timeout_d      = timeout_q;
        req_ready      = 1'b0;
        csr_commit     = 1'b0;
        tlb_flush_req  = 1'b0;
        icache_inv_req = 1'b0;
        redirect_valid = 1'b0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    kind_d  = req_kind_e'(req_kind);
                    pc_d    = req_next_pc;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pipe_empty) state_d = StCommit;
            end
            StCommit: begin
                csr_commit = (kind_q == KindSatpWr);
                cnt_d      = '0;
                state_d    = (kind_q == KindDrainOnly) ? StRedirect : StFlush;
            end
            StFlush: begin
                tlb_flush_req  = use_tlb;
                icache_inv_req = use_icache;
                cnt_d          = cnt_q + 8'd1;
                if (flush_ack) begin
                    state_d = StRedirect;
                end else if (cnt_last) begin
                    timeout_d = 1'b1;
                    state_d   = StRedirect;
                end
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy          = (state_q != StIdle);
    assign stall_fetch   = busy;
    assign redirect_pc   = pc_q;
    assign flush_timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            kind_q    <= KindSatpWr;
            pc_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/csr_serializer.md
CSR_SERIALIZER -- requirements
Module: csr_serializer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64: width of the redirect PC.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: maximum number of cycles spent waiting for a flush ack.
REQ-003 SHALL have port clk, input, 1: clock; reset is synchronous, active-high.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: decode presents a serializing instruction (satp write, sfence.vma or fence.i).
REQ-006 SHALL have port req_kind, input, 2: 0 SATP_WR, 1 SFENCE, 2 FENCE_I, 3 DRAIN_ONLY.
REQ-007 SHALL have port req_next_pc, input, REG_WIDTH: PC of the instruction following the request.
REQ-008 SHALL have port req_ready, output, 1: the request is accepted when req_valid and req_ready are both high.
REQ-009 SHALL have port pipe_empty, input, 1: every older instruction has retired.
REQ-010 SHALL have port stall_fetch, output, 1: holds the fetch stage.
REQ-011 SHALL have port csr_commit, output, 1: one-cycle write enable into the CSR file's valid/is_csr path.
REQ-012 SHALL have ports tlb_flush_req (output, 1) and tlb_flush_ack (input, 1): level request and ack for a TLB flush.
REQ-013 SHALL have ports icache_inv_req (output, 1) and icache_inv_ack (input, 1): level request and ack for an I-cache invalidate.
REQ-014 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, REG_WIDTH): a one-cycle fetch redirect.
REQ-015 SHALL have ports busy (output, 1) and flush_timeout (output, 1): busy is high in any state other than IDLE; flush_timeout is a sticky error flag.

Function
REQ-016 SHALL implement the FSM states IDLE, DRAIN, COMMIT, FLUSH and REDIRECT.
REQ-017 SHALL assert req_ready only in IDLE.
- On acceptance, latch req_kind and req_next_pc, then go to DRAIN.
REQ-018 SHALL assert stall_fetch in every state except IDLE.
REQ-019 DRAIN SHALL wait for pipe_empty.
- When pipe_empty is high, go to COMMIT on the next edge.
- pipe_empty already high on entry gives exactly one DRAIN cycle.
REQ-020 COMMIT SHALL last exactly one cycle.
- csr_commit = 1 in that cycle only when the kind is SATP_WR.
- Next state is FLUSH, or REDIRECT when the kind is DRAIN_ONLY.
REQ-021 FLUSH SHALL hold its request high until the matching ack is sampled high.
- SATP_WR and SFENCE hold tlb_flush_req.
- FENCE_I holds icache_inv_req.
- An ack in the first FLUSH cycle is honoured.
- The request drops in the cycle after the ack, together with the move to REDIRECT.
REQ-022 SHALL ignore acks sampled outside FLUSH, or for the non-selected resource.
REQ-023 SHALL run an 8-bit wait counter.
- The counter clears on entry to FLUSH and increments every cycle in FLUSH.
- When the count reaches ACK_TIMEOUT without an ack: drop the request, set flush_timeout, go to REDIRECT.
- A simultaneous ack at the timeout cycle wins: flush_timeout is not set.
REQ-024 REDIRECT SHALL last one cycle, with redirect_valid = 1 and redirect_pc = the latched PC, then return to IDLE.
REQ-025 SHALL give a minimum latency of 5 cycles from acceptance to IDLE when pipe_empty is high and the ack is immediate.
REQ-026 SHALL ignore req_valid while busy; requests are never queued.
REQ-027 SHALL hold redirect_pc at the latched value in all states (don't-care for consumers outside REDIRECT).

Reset
REQ-028 reset SHALL force IDLE in any state, including mid-FLUSH, and drop all requests the same edge.
REQ-029 SHALL reset these outputs to 0: stall_fetch, csr_commit, tlb_flush_req, icache_inv_req, redirect_valid, busy, flush_timeout.
REQ-030 SHALL reset redirect_pc to 0 and req_ready to 1.

Structure
REQ-031 SHALL place the req_kind enum, the FSM state enum and the satp/mepc CSR address constants in a shared package.
REQ-032 SHALL be a single flat module; the timeout counter is not worth its own sub-module.

Verification
REQ-033 SATP_WR, pipe_empty=1, tlb_flush_ack=1 in the first FLUSH cycle, pc=0x8000_1000:
- csr_commit at cycle 2.
- redirect_valid with pc 0x8000_1000 at cycle 4.
- IDLE at cycle 5.
REQ-034 FENCE_I with pipe_empty low for 6 cycles:
- Exactly 6 extra DRAIN cycles.
- icache_inv_req only, never tlb_flush_req.
- csr_commit stays 0.
REQ-035 SFENCE, no ack, ACK_TIMEOUT=4:
- tlb_flush_req high for 4 cycles.
- Then flush_timeout=1 and redirect issued.
- flush_timeout stays set until reset.
REQ-036 Second req_valid during DRAIN:
- req_ready=0 and the second request is ignored.
- After IDLE, the held request is accepted.
REQ-037 reset asserted in the second FLUSH cycle:
- Next cycle all outputs at reset values.
- No redirect_valid and no csr_commit pulse.
REQ-038 DRAIN_ONLY (kind 3):
- No flush request and no csr_commit.
- redirect at cycle 3.
